// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: writeback source indices, result-slot layout,
// default datapath widths and the round-robin pointer helper.
package pipeline_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_FLEN  = 32;
  localparam int DEF_TAG_W = 4;

  localparam int SRC_INT    = 0;
  localparam int SRC_FP     = 1;
  localparam int SRC_AGU    = 2;
  localparam int NUM_WB_SRC = 3;

  typedef struct packed {
    logic                 full;
    logic [4:0]           rd;
    logic [DEF_XLEN-1:0]  data;
    logic                 isf;
    logic [DEF_TAG_W-1:0] tag;
  } wb_slot_t;

  // Pointer value following a one-hot grant: the slot after the winner.
  function automatic logic [1:0] rr_next_ptr(input logic [2:0] gnt);
    logic [1:0] nxt;
    case (gnt)
      3'b001:  nxt = 2'd1;
      3'b010:  nxt = 2'd2;
      3'b100:  nxt = 2'd0;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Result-return bus between the execution sources (int ALU, FP ALU, AGU)
// and the writeback unit, plus the register-file write port it drives.
interface writeback_unit_if
  import pipeline_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int FLEN  = DEF_FLEN,
  parameter int TAG_W = DEF_TAG_W
);
  logic             int_valid_i, fp_valid_i, agu_valid_i;
  logic             int_ready_o, fp_ready_o, agu_ready_o;
  logic [4:0]       int_rd_i, fp_rd_i, agu_rd_i;
  logic [XLEN-1:0]  int_data_i, agu_data_i;
  logic [FLEN-1:0]  fp_data_i;
  logic             fp_isf_i;
  logic [TAG_W-1:0] int_tag_i, fp_tag_i, agu_tag_i;
  logic             rd_we_o, frd_we_o;
  logic [4:0]       wb_rd_o;
  logic [XLEN:0]    wb_g_o;
  logic             done_o;
  logic [TAG_W-1:0] done_tag_o;

  modport master (
    output int_valid_i, fp_valid_i, agu_valid_i,
    output int_rd_i, fp_rd_i, agu_rd_i,
    output int_data_i, agu_data_i, fp_data_i, fp_isf_i,
    output int_tag_i, fp_tag_i, agu_tag_i,
    input  int_ready_o, fp_ready_o, agu_ready_o,
    input  rd_we_o, frd_we_o, wb_rd_o, wb_g_o, done_o, done_tag_o
  );

  modport slave (
    input  int_valid_i, fp_valid_i, agu_valid_i,
    input  int_rd_i, fp_rd_i, agu_rd_i,
    input  int_data_i, agu_data_i, fp_data_i, fp_isf_i,
    input  int_tag_i, fp_tag_i, agu_tag_i,
    output int_ready_o, fp_ready_o, agu_ready_o,
    output rd_we_o, frd_we_o, wb_rd_o, wb_g_o, done_o, done_tag_o
  );

endinterface

// File: rtl/writeback_unit_rr_arb3.sv
// Three-request round-robin arbiter: one-hot grant starting the search at an
// internal pointer that moves past each winner and holds when idle.
module rr_arb3
  import pipeline_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] req,
  output logic [2:0] gnt
);

  logic [1:0] ptr_r;

  // Priority search beginning at the pointer.
  always_comb begin
    gnt = 3'b000;
    case (ptr_r)
      2'd0: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else             gnt = 3'b000;
      end
      2'd1: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else             gnt = 3'b000;
      end
      2'd2: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else             gnt = 3'b000;
      end
      default: gnt = 3'b000;
    endcase
  end

  // Pointer advances past each winner and holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_r <= 2'd0;
    end else if (|gnt) begin
      ptr_r <= rr_next_ptr(gnt);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: one holding slot per result source, round-robin onto the
// single register-file write port. Optional FP write path under WB_FPREGS_EN.
module writeback_unit
  import pipeline_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int FLEN  = DEF_FLEN,
  parameter int TAG_W = DEF_TAG_W
)(
  input  logic             clk,
  input  logic             resetn,
  writeback_unit_if.slave  wb
);

  wb_slot_t              slot_r [NUM_WB_SRC];
  wb_slot_t              in_s   [NUM_WB_SRC];
  wb_slot_t              sel_s;
  logic [NUM_WB_SRC-1:0] req_s, gnt_s, valid_s, ready_s, acc_s;

  logic             rd_we_r, done_r;
  logic [4:0]       wb_rd_r;
  logic [XLEN:0]    wb_g_r;
  logic [TAG_W-1:0] done_tag_r;

  // Incoming results in slot form; FP data is zero-extended on capture.
  always_comb begin
    in_s[SRC_INT] = '{full: 1'b1, rd: wb.int_rd_i, data: wb.int_data_i,
                      isf: 1'b0, tag: wb.int_tag_i};
    in_s[SRC_AGU] = '{full: 1'b1, rd: wb.agu_rd_i, data: wb.agu_data_i,
                      isf: 1'b0, tag: wb.agu_tag_i};
`ifdef WB_FPREGS_EN
    in_s[SRC_FP]  = '{full: 1'b1, rd: wb.fp_rd_i, data: XLEN'(wb.fp_data_i),
                      isf: wb.fp_isf_i, tag: wb.fp_tag_i};
`else
    in_s[SRC_FP]  = '{full: 1'b1, rd: wb.fp_rd_i, data: XLEN'(wb.fp_data_i),
                      isf: 1'b0, tag: wb.fp_tag_i};
`endif
  end

  always_comb begin
    for (int i = 0; i < NUM_WB_SRC; i++) begin
      req_s[i] = slot_r[i].full;
    end
  end

  rr_arb3 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    (req_s),
    .gnt    (gnt_s)
  );

  // A slot being drained this cycle can take a new result immediately.
  assign valid_s = {wb.agu_valid_i, wb.fp_valid_i, wb.int_valid_i};
  always_comb begin
    for (int i = 0; i < NUM_WB_SRC; i++) begin
      ready_s[i] = ~slot_r[i].full | gnt_s[i];
    end
  end
  assign acc_s          = valid_s & ready_s;
  assign wb.int_ready_o = ready_s[SRC_INT];
  assign wb.fp_ready_o  = ready_s[SRC_FP];
  assign wb.agu_ready_o = ready_s[SRC_AGU];

  // Slot update: refill wins over drain, so grant+refill keeps the slot full.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WB_SRC; i++) begin
      if (!resetn) begin
        slot_r[i] <= '0;
      end else if (acc_s[i]) begin
        slot_r[i] <= in_s[i];
      end else if (gnt_s[i]) begin
        slot_r[i].full <= 1'b0;
      end else begin
        slot_r[i] <= slot_r[i];
      end
    end
  end

  // Granted slot contents.
  always_comb begin
    sel_s = '0;
    case (gnt_s)
      3'b001:  sel_s = slot_r[SRC_INT];
      3'b010:  sel_s = slot_r[SRC_FP];
      3'b100:  sel_s = slot_r[SRC_AGU];
      default: sel_s = '0;
    endcase
  end

`ifdef WB_FPREGS_EN
  logic frd_we_r;
  assign wb.frd_we_o = frd_we_r;
`else
  assign wb.frd_we_o = 1'b0;
`endif

  // Output stage: exactly one registered writeback per grant, pending bit 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_we_r    <= 1'b0;
`ifdef WB_FPREGS_EN
      frd_we_r   <= 1'b0;
`endif
      done_r     <= 1'b0;
      wb_rd_r    <= 5'd0;
      wb_g_r     <= '0;
      done_tag_r <= '0;
    end else begin
      rd_we_r  <= 1'b0;
`ifdef WB_FPREGS_EN
      frd_we_r <= 1'b0;
`endif
      done_r   <= 1'b0;
      if (|gnt_s) begin
        done_r     <= 1'b1;
        done_tag_r <= sel_s.tag;
        wb_rd_r    <= sel_s.rd;
        if (sel_s.isf) begin
`ifdef WB_FPREGS_EN
          frd_we_r <= 1'b1;
`endif
          wb_g_r   <= {1'b0, XLEN'(sel_s.data[FLEN-1:0])};
        end else begin
          rd_we_r  <= (sel_s.rd != 5'd0);
          wb_g_r   <= {1'b0, sel_s.data};
        end
      end else begin
        wb_rd_r <= wb_rd_r;
        wb_g_r  <= wb_g_r;
      end
    end
  end

  assign wb.rd_we_o    = rd_we_r;
  assign wb.done_o     = done_r;
  assign wb.wb_rd_o    = wb_rd_r;
  assign wb.wb_g_o     = wb_g_r;
  assign wb.done_tag_o = done_tag_r;

endmodule
